fsm_seq_generator: RTL and testbench
====================================

# fsm_seq_generator

Serial bit-sequence generator: the transmitting end of the serial pattern path feeding the team's FSM sequence detectors. It accepts a WIDTH-bit pattern and a repeat count over a start/ready handshake, then shifts the pattern out MSB-first on a single-bit line, one bit per clock, with a programmable idle gap between repetitions. It lives in the FSM-modelling test infrastructure and drives detector `x` inputs directly.

## Interface
- WIDTH, 10, pattern length in bits (≥2)
- CNT_W, 4, width of repeat count
- GAP, 2, idle cycles between repetitions (0 allowed)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted on a rising edge when ready=1
- pattern  in  WIDTH  bits to send, MSB first; latched on accept
- repeat_n  in  CNT_W  extra repetitions; frames sent = repeat_n+1; latched on accept
- ready  out  1  high exactly when in IDLE
- x  out  1  serial data bit
- x_valid  out  1  x carries a pattern (or parity) bit this cycle
- done  out  1  one-cycle pulse after the last bit of the last frame

## Operation
- States: IDLE, SHIFT, PAR (only with parity macro), GAP.
- IDLE: ready=1, x=0, x_valid=0. start=1 latches pattern into shift register, repeat_n into rep counter, clears bit counter, goes to SHIFT.
- SHIFT: x=shreg[WIDTH-1], x_valid=1; shreg shifts left each cycle; bit counter counts 0..WIDTH-1. After bit WIDTH-1:
  - parity enabled → PAR;
  - else if rep counter=0 → IDLE with done=1;
  - else if GAP=0 → reload shreg from latched pattern, decrement rep counter, stay in SHIFT (continuous bits);
  - else → GAP, decrement rep counter, reload shreg.
- PAR: x=parity bit, x_valid=1, for one cycle; then same exit rules as end of SHIFT.
- GAP: x=0, x_valid=0 for exactly GAP cycles (gap counter), then SHIFT.
- start while ready=0 is ignored; pattern/repeat_n changes after accept have no effect.
- done is registered: high in the first IDLE cycle following the final bit, ready=1 that same cycle; start in that cycle is accepted.

## Timing
- Reset values: ready=1, x=0, x_valid=0, done=0, state IDLE, all counters 0.
- rst asserted mid-frame: outputs return to reset values immediately (asynchronous); no done pulse; frame abandoned.
- Latency: start accepted at edge 0 → first bit (pattern MSB) valid in cycle 1.
- Frame length F = WIDTH (+1 with parity). Total cycles with ready=0 = (repeat_n+1)·F + repeat_n·GAP; done in the next cycle.
- Counters saturate-free: bit counter ⌈log2(WIDTH+1)⌉ bits, gap counter ⌈log2(GAP+1)⌉ bits (min 1), rep counter CNT_W bits; repeat_n = all-ones is legal (2^CNT_W frames).

## Configuration
- SEQ_GEN_PARITY_EN defined: each frame appended with one even-parity bit (XOR of latched pattern) in PAR state, x_valid=1; F=WIDTH+1.
- Undefined: PAR state and parity logic absent; F=WIDTH.

## Test plan
- pattern=10'b1110000111, repeat_n=0, start at edge 0 → x=1,1,1,0,0,0,0,1,1,1 with x_valid=1 in cycles 1–10; done=1 and ready=1 in cycle 11 only.
- Same pattern, repeat_n=2, GAP=2 → frames in cycles 1–10, 13–22, 25–34; x_valid=0 in 11–12, 23–24; done in cycle 35.
- start held high continuously, repeat_n=0 → start re-accepted on each done cycle; next frame begins the following cycle, one-cycle bubble (x_valid=0) between frames; start pulses during busy ignored.
- rst asserted in cycle 5 of a frame → ready=1, x=0, x_valid=0, done=0 immediately; after release, new start sends full fresh frame.
- With SEQ_GEN_PARITY_EN, pattern=10'b1110000111 (6 ones) → cycle 11 x=0, x_valid=1; pattern=10'b1000000000 → cycle 11 x=1; done in cycle 12.
- GAP=0 build, pattern=10'b1111111111, repeat_n=1 → x_valid=1 for cycles 1–20 uninterrupted; connected detector z high from its third-bit onward through cycle 20.

Source files
------------

// File: rtl/fsm_seq_generator_if.sv
// Handshake and serial-output bundle of the bit-sequence generator.
// The master side (test stimulus) issues requests; the slave side (generator) drives the line.
interface fsm_seq_generator_if #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic             done;

  modport master (output start, pattern, repeat_n, input ready, x, x_valid, done);
  modport slave  (input start, pattern, repeat_n, output ready, x, x_valid, done);
endinterface

// File: rtl/fsm_seq_generator.sv
// Serial bit-sequence generator: sends a latched pattern MSB-first (repeat_n+1) times with GAP idle cycles between frames.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
module fsm_seq_generator #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input logic               clk,
  input logic               rst,
  fsm_seq_generator_if.slave bus
);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP < 1) ? 0 : GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef SEQ_GEN_PARITY_EN
    S_PAR   = 2'd2,
`endif
    S_GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               done_q, done_d;
  logic               frame_end;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    done_d      = 1'b0;
    frame_end   = 1'b0;
    bus.ready   = 1'b0;
    bus.x       = 1'b0;
    bus.x_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          pat_d   = bus.pattern;
          shreg_d = bus.pattern;
          rep_d   = bus.repeat_n;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bus.x       = shreg_q[WIDTH-1];
        bus.x_valid = 1'b1;
        shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
`ifdef SEQ_GEN_PARITY_EN
          state_d = S_PAR;
`else
          frame_end = 1'b1;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      S_PAR: begin
        bus.x       = ^pat_q;
        bus.x_valid = 1'b1;
        frame_end   = 1'b1;
      end
`endif
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Last bit of a frame: finish, or reload the pattern for the next repetition.
    if (frame_end) begin
      if (rep_q == '0) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        rep_d   = rep_q - 1'b1;
        shreg_d = pat_q;
        state_d = (GAP == 0) ? S_SHIFT : S_GAP;
      end
    end
  end

  assign bus.done = done_q;

endmodule

// File: tb/tb_fsm_seq_generator.sv
// Scoreboard bench for fsm_seq_generator: expected bits/done pulses are queued with their cycle stamps
// at request time and a negedge monitor pops and compares whatever the generators present.
module tb_fsm_seq_generator;
  localparam int W     = 10;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;
`ifdef SEQ_GEN_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  typedef struct {
    int   dut;
    int   cyc;
    logic is_done;
    logic x;
  } item_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  item_t exp_q[$];
  item_t it;
  logic  m_xv, m_x, m_dn, m_rd;

  fsm_seq_generator_if #(.WIDTH(W), .CNT_W(CNT_W)) bus ();
  fsm_seq_generator_if #(.WIDTH(W), .CNT_W(CNT_W)) bus0 ();

  fsm_seq_generator #(.WIDTH(W), .CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fsm_seq_generator #(.WIDTH(W), .CNT_W(CNT_W), .GAP(0)) dut_gap0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame model: bits MSB-first from cycle c0, optional parity bit, gap cycles between frames, done after the last.
  function automatic void push_run(input int d, input int c0, input logic [W-1:0] pat,
                                   input int rep, input int gap);
    int c = c0;
    for (int f = 0; f <= rep; f++) begin
      for (int i = W - 1; i >= 0; i--) begin
        exp_q.push_back('{d, c, 1'b0, pat[i]});
        c++;
      end
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back('{d, c, 1'b0, ^pat});
      c++;
`endif
      if (f < rep) c += gap;
    end
    exp_q.push_back('{d, c, 1'b1, 1'b0});
  endfunction

  // Called #1 after a rising edge with the target idle; returns #1 after the accepting edge.
  task automatic issue(input int d, input logic [W-1:0] pat, input logic [CNT_W-1:0] rep, input int gap);
    int c;
    if (d == 0) begin
      bus.start = 1'b1; bus.pattern = pat; bus.repeat_n = rep;
    end else begin
      bus0.start = 1'b1; bus0.pattern = pat; bus0.repeat_n = rep;
    end
    @(posedge clk); #1;
    c = cyc;
    push_run(d, c, pat, int'(rep), gap);
    // Post-accept input changes must not affect the frame.
    if (d == 0) begin
      bus.start = 1'b0; bus.pattern = ~pat; bus.repeat_n = '0;
    end else begin
      bus0.start = 1'b0; bus0.pattern = ~pat; bus0.repeat_n = '0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        m_xv = (d == 0) ? bus.x_valid : bus0.x_valid;
        m_x  = (d == 0) ? bus.x       : bus0.x;
        m_dn = (d == 0) ? bus.done    : bus0.done;
        m_rd = (d == 0) ? bus.ready   : bus0.ready;
        if (m_xv || m_dn) begin
          if (exp_q.size() == 0) begin
            check("spurious_output", {30'd0, m_xv, m_dn}, 0);
          end else begin
            it = exp_q.pop_front();
            check("source_dut", d, it.dut);
            check("cycle", cyc, it.cyc);
            check("is_done", m_dn, it.is_done);
            check("ready", m_rd, it.is_done);
            if (!it.is_done) check("x_bit", m_x, it.x);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.start = 1'b0;  bus.pattern = '0;  bus.repeat_n = '0;
    bus0.start = 1'b0; bus0.pattern = '0; bus0.repeat_n = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_x", bus.x, 0);
    check("rst_x_valid", bus.x_valid, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single frame, then three frames with gaps plus an ignored start pulse while busy.
    issue(0, 10'b1110000111, 4'd0, GAP);
    wait_drain(400);
    issue(0, 10'b1110000111, 4'd2, GAP);
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_drain(400);

    // start held high: re-accepted in every done cycle, one-cycle bubble between frames.
    bus.start = 1'b1; bus.pattern = 10'b1110000111; bus.repeat_n = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      c = cyc;
      push_run(0, c, 10'b1110000111, 0, GAP);
      if (k == 2) bus.start = 1'b0;
      else repeat (F) @(posedge clk);
    end
    wait_drain(400);

    issue(0, 10'b1000000000, 4'd0, GAP);
    wait_drain(400);

    // Asynchronous reset in the fifth bit of a frame, then a fresh frame.
    bus.start = 1'b1; bus.pattern = 10'b1110000111; bus.repeat_n = 4'd0;
    @(posedge clk); #1;
    c = cyc;
    bus.start = 1'b0;
    push_run(0, c, 10'b1110000111, 0, GAP);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", bus.ready, 1);
    check("midrst_x", bus.x, 0);
    check("midrst_x_valid", bus.x_valid, 0);
    check("midrst_done", bus.done, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 10'b0110110001, 4'd0, GAP);
    wait_drain(400);

    // repeat_n all-ones: 16 frames.
    issue(0, 10'b1010011001, 4'hF, GAP);
    wait_drain(800);

    // GAP=0 build: back-to-back frames with no idle cycle.
    issue(1, 10'b1111111111, 4'd1, 0);
    wait_drain(400);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
